systolic_feeder: RTL and testbench

- Upstream stage of Systolic_array.
- Buffers one input vector and one PE_NUMBER x PE_NUMBER weight matrix, loaded through valid/data streams.
- On start it clears the array, drives the diagonally skewed operands (l_d_i, pe_t_w), then holds the array's read strobe.
- Replaces the hand-written stimulus sequencing in front of the array; driven by Controller / CSR-side logic.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/systolic_feeder_if.sv | 35 +++
 rtl/systolic_feeder_buf.sv | 71 +++++++
 rtl/systolic_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_feeder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and constants for the systolic array feeder
// Contents: feeder_state_t FSM encoding, default operand width / array size,
// and a clog2 helper that never returns a zero-width result.
package sa_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_PE_NUMBER  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FEED,
    DONE
  } feeder_state_t;

  // Counters and pointers need at least one bit even when N collapses to 1.
  function automatic int safe_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - load/start/array-side bundle of the feeder
// slave modport (feeder side):
//   in : vec_valid, vec_data, mat_valid, mat_data, start
//   out: vec_ready, mat_ready, sa_clear, l_d_o, pe_t_w_o[0:N-1], sa_read, busy, done
// master modport is the mirror image for the controller / CSR side.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUMBER  = 3
);

  logic                  vec_valid;
  logic [DATA_WIDTH-1:0] vec_data;
  logic                  vec_ready;
  logic                  mat_valid;
  logic [DATA_WIDTH-1:0] mat_data;
  logic                  mat_ready;
  logic                  start;
  logic                  sa_clear;
  logic [DATA_WIDTH-1:0] l_d_o;
  logic [DATA_WIDTH-1:0] pe_t_w_o [0:PE_NUMBER-1];
  logic                  sa_read;
  logic                  busy;
  logic                  done;

  modport slave (
    input  vec_valid, vec_data, mat_valid, mat_data, start,
    output vec_ready, mat_ready, sa_clear, l_d_o, pe_t_w_o, sa_read, busy, done
  );

  modport master (
    output vec_valid, vec_data, mat_valid, mat_data, start,
    input  vec_ready, mat_ready, sa_clear, l_d_o, pe_t_w_o, sa_read, busy, done
  );

endinterface

// File: rtl/systolic_feeder_buf.sv
// rtl/systolic_feeder_buf.sv - vector/matrix storage with skewed operand read
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset (pointers only)
//   vec_we_i, vec_data_i     vector element write at the vector pointer
//   mat_we_i, mat_data_i     matrix element write at flat index k*N+j
//   ptr_clr_i                return both pointers to 0 (a same-cycle write still
//                            lands at the old pointer)
//   f_i                      feed counter
//   l_d_o, pe_t_w_o          combinational skewed operands for feed step f_i
module feeder_buf
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PE_NUMBER  = DEF_PE_NUMBER,
  parameter int F_W        = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  vec_we_i,
  input  logic [DATA_WIDTH-1:0] vec_data_i,
  input  logic                  mat_we_i,
  input  logic [DATA_WIDTH-1:0] mat_data_i,
  input  logic                  ptr_clr_i,
  input  logic [F_W-1:0]        f_i,
  output logic [DATA_WIDTH-1:0] l_d_o,
  output logic [DATA_WIDTH-1:0] pe_t_w_o [0:PE_NUMBER-1]
);

  localparam int N    = PE_NUMBER;
  localparam int VP_W = safe_clog2(N);
  localparam int MP_W = safe_clog2(N * N);

  logic [DATA_WIDTH-1:0] vec_buf_q [0:N-1];
  logic [DATA_WIDTH-1:0] mat_buf_q [0:N*N-1];
  logic [VP_W-1:0]       vec_ptr_q;
  logic [MP_W-1:0]       mat_ptr_q;

  // Storage is deliberately not reset so a reset mid-run keeps the operands.
  always_ff @(posedge clk_i) begin
    if (vec_we_i) vec_buf_q[vec_ptr_q] <= vec_data_i;
    if (mat_we_i) mat_buf_q[mat_ptr_q] <= mat_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vec_ptr_q <= '0;
      mat_ptr_q <= '0;
    end else begin
      if (ptr_clr_i)     vec_ptr_q <= '0;
      else if (vec_we_i) vec_ptr_q <= (vec_ptr_q == VP_W'(N - 1)) ? '0 : vec_ptr_q + VP_W'(1);
      if (ptr_clr_i)     mat_ptr_q <= '0;
      else if (mat_we_i) mat_ptr_q <= (mat_ptr_q == MP_W'(N * N - 1)) ? '0 : mat_ptr_q + MP_W'(1);
    end
  end

  // Row k sees column j at feed step f = k + j, which produces the diagonal
  // skew; steps outside a row's window read as 0.
  always_comb begin
    l_d_o = '0;
    for (int k = 0; k < N; k++) pe_t_w_o[k] = '0;
    for (int j = 0; j < N; j++) begin
      if (f_i == F_W'(j)) l_d_o = vec_buf_q[j];
    end
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (f_i == F_W'(k + j)) pe_t_w_o[k] = mat_buf_q[k*N + j];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - sequencer that clears, feeds and reads a systolic array
// Ports:
//   clk, reset   single clock, synchronous active-low reset
//   bus          systolic_feeder_if.slave: load streams, start, array-side outputs
// Array-side outputs are registered from the current state, so they trail the
// state by one cycle; ready/busy are registered from the next state so they
// line up with the state the load logic actually sees.
module systolic_feeder
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PE_NUMBER  = DEF_PE_NUMBER
) (
  input logic               clk,
  input logic               reset,
  systolic_feeder_if.slave  bus
);

  localparam int N   = PE_NUMBER;
  localparam int F_W = safe_clog2(2 * N);

  feeder_state_t         state_q, state_d;
  logic [F_W-1:0]        cnt_q, cnt_d;
  logic                  sa_clear_q, sa_clear_d;
  logic                  sa_read_q, sa_read_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] l_d_q, l_d_d;
  logic [DATA_WIDTH-1:0] pe_q [0:N-1];
  logic [DATA_WIDTH-1:0] pe_d [0:N-1];
  logic [DATA_WIDTH-1:0] buf_l_d;
  logic [DATA_WIDTH-1:0] buf_pe [0:N-1];
  logic                  start_acc, vec_we, mat_we;

  assign start_acc = bus.start && (state_q == IDLE || state_q == DONE);
  assign vec_we    = bus.vec_valid && ready_q && reset;
  assign mat_we    = bus.mat_valid && ready_q && reset;

  feeder_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .PE_NUMBER (N),
    .F_W       (F_W)
  ) u_buf (
    .clk_i     (clk),
    .rst_ni    (reset),
    .vec_we_i  (vec_we),
    .vec_data_i(bus.vec_data),
    .mat_we_i  (mat_we),
    .mat_data_i(bus.mat_data),
    .ptr_clr_i (start_acc),
    .f_i       (cnt_q),
    .l_d_o     (buf_l_d),
    .pe_t_w_o  (buf_pe)
  );

  // cnt_q counts CLEAR cycles, then feed steps; in DONE it marks the first cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == F_W'(N - 1)) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + F_W'(1);
        end
      end
      FEED: begin
        if (cnt_q == F_W'(2 * N - 2)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + F_W'(1);
        end
      end
      DONE: begin
        if (start_acc) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = F_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sa_clear_d = (state_q == CLEAR);
    l_d_d      = (state_q == FEED) ? buf_l_d : '0;
    for (int k = 0; k < N; k++) pe_d[k] = (state_q == FEED) ? buf_pe[k] : '0;
    sa_read_d  = (state_q == DONE) && !start_acc;
    done_d     = (state_q == DONE) && (cnt_q == '0);
    busy_d     = (state_d == CLEAR) || (state_d == FEED);
    ready_d    = !busy_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sa_clear_q <= 1'b0;
      sa_read_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      l_d_q      <= '0;
      for (int k = 0; k < N; k++) pe_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sa_clear_q <= sa_clear_d;
      sa_read_q  <= sa_read_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      l_d_q      <= l_d_d;
      for (int k = 0; k < N; k++) pe_q[k] <= pe_d[k];
    end
  end

  assign bus.vec_ready = ready_q;
  assign bus.mat_ready = ready_q;
  assign bus.sa_clear  = sa_clear_q;
  assign bus.l_d_o     = l_d_q;
  assign bus.sa_read   = sa_read_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  for (genvar g = 0; g < N; g++) begin : g_pe_out
    assign bus.pe_t_w_o[g] = pe_q[g];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder
module tb_systolic_feeder;

  localparam int N  = 3;
  localparam int DW = 16;

  typedef struct packed {
    logic          clr;
    logic [DW-1:0] l;
    logic [DW-1:0] p0;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;
    logic          rd;
    logic          dn;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_WIDTH(DW), .PE_NUMBER(N)) bus ();

  systolic_feeder #(.DATA_WIDTH(DW), .PE_NUMBER(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Hand-computed skewed matrix operands for mat 1,7,9 / 6,3,5 / 2,7,2.
  logic [DW-1:0] pe_tab  [0:4][0:2] = '{'{1, 0, 0}, '{7, 6, 0}, '{9, 3, 2}, '{0, 5, 7}, '{0, 0, 2}};
  logic [DW-1:0] mat_std [0:8]      = '{1, 7, 9, 6, 3, 5, 2, 7, 2};
  logic [DW-1:0] vec_std [0:2]      = '{8, 10, 4};

  cyc_t exp_q[$];
  int   len_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  // Expected outputs for edges t+1..t+10 after a start sampled at edge t.
  task automatic push_run(input logic [DW-1:0] l0, l1, l2, input bit abort);
    logic [DW-1:0] lv [0:2];
    cyc_t e;
    lv[0] = l0; lv[1] = l1; lv[2] = l2;
    for (int i = 0; i < 10; i++) begin
      e = '0;
      if (i < 3) e.clr = 1'b1;
      else if (i < 8) begin
        e.l  = (i - 3 < 3) ? lv[i-3] : '0;
        e.p0 = pe_tab[i-3][0];
        e.p1 = pe_tab[i-3][1];
        e.p2 = pe_tab[i-3][2];
      end else begin
        e.rd = 1'b1;
        e.dn = (i == 8);
      end
      if (abort && i == 4) begin
        exp_q.push_back(cyc_t'(0));
        break;
      end
      exp_q.push_back(e);
    end
    len_q.push_back(abort ? 5 : 10);
  endtask

  // Monitor: each rising sa_clear marks the start of a run and consumes one
  // queued run expectation, cycle by cycle.
  logic prev_clr = 1'b0;
  int   mon_n;
  int   mon_run = 0;
  cyc_t mon_act, mon_exp;
  always @(negedge clk) begin
    if (bus.sa_clear === 1'b1 && !prev_clr) begin
      chk("run_expected", len_q.size(), 1);
      if (len_q.size() > 0) begin
        mon_n = len_q.pop_front();
        for (int i = 0; i < mon_n; i++) begin
          if (i > 0) @(negedge clk);
          mon_act = {bus.sa_clear, bus.l_d_o, bus.pe_t_w_o[0], bus.pe_t_w_o[1],
                     bus.pe_t_w_o[2], bus.sa_read, bus.done};
          mon_exp = exp_q.pop_front();
          checks++;
          if (mon_act !== mon_exp) begin
            failures++;
            $display("FAIL run%0d_cyc%0d act=%h exp=%h", mon_run, i + 1, mon_act, mon_exp);
          end
        end
        mon_run++;
      end
    end
    prev_clr = (bus.sa_clear === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_vec(input logic [DW-1:0] d);
    bus.vec_valid = 1'b1;
    bus.vec_data  = d;
    tick();
    bus.vec_valid = 1'b0;
  endtask

  task automatic load_std();
    for (int i = 0; i < 9; i++) begin
      bus.mat_valid = 1'b1;
      bus.mat_data  = mat_std[i];
      bus.vec_valid = (i < 3);
      bus.vec_data  = (i < 3) ? vec_std[i] : '0;
      tick();
    end
    bus.mat_valid = 1'b0;
    bus.vec_valid = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] l0, l1, l2, input bit disturb, input bit abort,
                     input bit wr_with_start, input logic [DW-1:0] wd);
    push_run(l0, l1, l2, abort);
    bus.start = 1'b1;
    if (wr_with_start) begin
      bus.vec_valid = 1'b1;
      bus.vec_data  = wd;
    end
    tick();
    bus.start     = 1'b0;
    bus.vec_valid = 1'b0;
    chk("sa_read_after_start", bus.sa_read, 0);
    chk("busy_after_start", bus.busy, 1);
    for (int i = 1; i <= 10; i++) begin
      if (abort && i == 5) begin
        reset = 1'b0;
        tick();
        chk("abort_l_d", bus.l_d_o, 0);
        chk("abort_busy", bus.busy, 0);
        reset = 1'b1;
        tick();
        chk("abort_ready", bus.vec_ready, 1);
        chk("abort_sa_read", bus.sa_read, 0);
        break;
      end
      if (disturb && i == 5) begin
        chk("busy_vec_ready", bus.vec_ready, 0);
        chk("busy_mat_ready", bus.mat_ready, 0);
        bus.vec_valid = 1'b1;
        bus.vec_data  = 16'd99;
        bus.mat_valid = 1'b1;
        bus.mat_data  = 16'd99;
        bus.start     = 1'b1;
        tick();
        bus.vec_valid = 1'b0;
        bus.mat_valid = 1'b0;
        bus.start     = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    bus.vec_valid = 1'b0;
    bus.vec_data  = '0;
    bus.mat_valid = 1'b0;
    bus.mat_data  = '0;
    bus.start     = 1'b0;
    reset         = 1'b0;
    tick();
    tick();
    chk("rst_sa_clear", bus.sa_clear, 0);
    chk("rst_l_d", bus.l_d_o, 0);
    chk("rst_sa_read", bus.sa_read, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_vec_ready", bus.vec_ready, 0);
    reset = 1'b1;
    tick();
    chk("idle_vec_ready", bus.vec_ready, 1);
    chk("idle_mat_ready", bus.mat_ready, 1);

    load_std();
    run(8, 10, 4, 0, 0, 0, 0);   // baseline from IDLE
    run(8, 10, 4, 1, 0, 0, 0);   // back-to-back from DONE, writes/start during FEED
    run(8, 10, 4, 0, 0, 0, 0);   // buffers untouched by the dropped writes
    run(8, 10, 4, 0, 1, 0, 0);   // reset at t+5
    run(8, 10, 4, 0, 0, 0, 0);   // replay from retained buffers
    wr_vec(1); wr_vec(2); wr_vec(3); wr_vec(4);
    run(4, 2, 3, 0, 0, 0, 0);    // vector pointer wrap
    wr_vec(5);
    run(5, 6, 3, 0, 0, 1, 6);    // write alongside start lands at old pointer
    wr_vec(9);
    run(9, 6, 3, 0, 0, 0, 0);    // pointer was cleared by the start

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("run_queue_drained", len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
